// File: rtl/pkt_len_chk.sv
// pkt_len_chk: forwards the byte stream with 1-cycle latency, checks packet length/framing, keeps saturating stats
module pkt_len_chk #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1536,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       din,
  input  logic             din_vld,
  input  logic             din_sop,
  input  logic             din_eop,
  output logic [7:0]       dout,
  output logic             dout_vld,
  output logic             dout_sop,
  output logic             dout_eop,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_len_vld,
  output logic [2:0]       pkt_err,
  output logic [LEN_W-1:0] good_cnt,
  output logic [LEN_W-1:0] bad_cnt,
  output logic [LEN_W-1:0] orphan_cnt
);
  typedef enum logic {IDLE, IN_PKT} state_t;
  localparam logic [LEN_W-1:0] SAT   = '1;
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  state_t           state, state_nx;
  logic [LEN_W-1:0] len, len_nx, len_inc, a_len;
  logic             orphan, fwd, cl_a, cl_b, a_frm;
  logic [2:0]       a_err, b_err;
  logic             pnd_vld, pnd_vld_nx, out_vld;
  logic [LEN_W-1:0] pnd_len, pnd_len_nx, out_len;
  logic [2:0]       pnd_err, pnd_err_nx, out_err;

  function automatic logic [2:0] err_of(input logic [LEN_W-1:0] l, input logic f);
    return {f, l > MAX_L, l < MIN_L};
  endfunction

  // cl_a is the first packet closed this cycle; cl_b the single-byte packet that follows an abort
  always_comb begin
    state_nx = state;
    len_nx   = len;
    cl_a     = 1'b0;
    cl_b     = 1'b0;
    a_frm    = 1'b0;
    len_inc  = (len == SAT) ? len : len + ONE;
    a_len    = len_inc;
    orphan   = din_vld && state == IDLE && !din_sop;
    fwd      = din_vld && !orphan;
    if (din_vld && din_sop) begin
      len_nx   = ONE;
      state_nx = din_eop ? IDLE : IN_PKT;
      cl_a     = (state == IN_PKT) || din_eop;
      cl_b     = (state == IN_PKT) && din_eop;
      a_frm    = state == IN_PKT;
      a_len    = (state == IN_PKT) ? len : ONE;
    end else if (din_vld && state == IN_PKT) begin
      len_nx   = len_inc;
      cl_a     = din_eop;
      state_nx = din_eop ? IDLE : IN_PKT;
    end
  end

  // A pending report always goes out first; a pending slot is never full while IN_PKT,
  // because entering IN_PKT takes a close-free cycle that drains it.
  always_comb begin
    a_err      = err_of(a_len, a_frm);
    b_err      = err_of(ONE, 1'b0);
    out_vld    = pnd_vld || cl_a;
    out_len    = pnd_vld ? pnd_len : a_len;
    out_err    = pnd_vld ? pnd_err : a_err;
    pnd_vld_nx = pnd_vld ? cl_a : cl_b;
    pnd_len_nx = pnd_vld ? a_len : ONE;
    pnd_err_nx = pnd_vld ? a_err : b_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len   <= '0;
    end else begin
      state <= state_nx;
      len   <= len_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout        <= '0;
      dout_vld    <= 1'b0;
      dout_sop    <= 1'b0;
      dout_eop    <= 1'b0;
      pkt_len     <= '0;
      pkt_len_vld <= 1'b0;
      pkt_err     <= '0;
      pnd_vld     <= 1'b0;
      pnd_len     <= '0;
      pnd_err     <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      orphan_cnt  <= '0;
    end else begin
      dout        <= fwd ? din : dout;
      dout_vld    <= fwd;
      dout_sop    <= fwd && din_sop;
      dout_eop    <= fwd && din_eop;
      pkt_len     <= out_vld ? out_len : pkt_len;
      pkt_len_vld <= out_vld;
      pkt_err     <= out_vld ? out_err : pkt_err;
      pnd_vld     <= pnd_vld_nx;
      pnd_len     <= pnd_len_nx;
      pnd_err     <= pnd_err_nx;
      if (out_vld && out_err == 3'b000)
        good_cnt <= good_cnt + LEN_W'(good_cnt != SAT);
      if (out_vld && out_err != 3'b000)
        bad_cnt <= bad_cnt + LEN_W'(bad_cnt != SAT);
      if (orphan)
        orphan_cnt <= orphan_cnt + LEN_W'(orphan_cnt != SAT);
    end
  end
endmodule
